// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: default sizes,
// the read-mode encoding and elaboration-time parameter helpers.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 16;

    typedef enum logic {
        READ_STD  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit levels_ok(input int unsigned ae_level,
                                     input int unsigned af_level,
                                     input int unsigned depth);
        return (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// DEPTH x DATA_WIDTH flop array: synchronous write port, asynchronous read port.
module sfifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered count/threshold flags,
// sticky overflow/underflow and selectable standard or FWFT read stage.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_DEPTH,
    parameter  int unsigned FWFT       = 0,
    parameter  int unsigned AF_LEVEL   = DEPTH - 2,
    parameter  int unsigned AE_LEVEL   = 2,
    localparam int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam read_mode_e READ_MODE = (FWFT != 0) ? READ_FWFT : READ_STD;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two and at least 4");
    end
    if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_levels
        $error("param_sync_fifo: require AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("param_sync_fifo: DATA_WIDTH must be at least 1");
    end

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_next;
    logic [ADDR_WIDTH:0]   rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Pointer difference modulo 2*DEPTH equals count + wr_acc - rd_acc.
    always_comb begin
        wr_acc      = wr_en && !full;
        rd_acc      = rd_en && !empty;
        wr_ptr_next = wr_ptr + (ADDR_WIDTH + 1)'(wr_acc);
        rd_ptr_next = rd_ptr + (ADDR_WIDTH + 1)'(rd_acc);
        count_next  = wr_ptr_next - rd_ptr_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= (count_next == DEPTH_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    sfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    if (READ_MODE == READ_FWFT) begin : g_fwft
        // Masked while empty so the unreset storage never shows on rd_data.
        assign rd_data  = empty ? '0 : ram_rdata;
        assign rd_valid = !empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) begin
                    rd_data <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench: standard-mode FIFO (dut_std) and FWFT FIFO (dut_fwft).
module tb_param_sync_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    logic          b_wr_en, b_rd_en, b_clr_err;
    logic [DW-1:0] b_wr_data;
    logic [DW-1:0] b_rd_data;
    logic          b_rd_valid, b_full, b_empty, b_almost_full, b_almost_empty;
    logic [3:0]    b_count;
    logic          b_overflow, b_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .FWFT       (0),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut_std (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    param_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .FWFT       (1),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut_fwft (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (b_wr_en),
        .wr_data      (b_wr_data),
        .rd_en        (b_rd_en),
        .clr_err      (b_clr_err),
        .rd_data      (b_rd_data),
        .rd_valid     (b_rd_valid),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_almost_full),
        .almost_empty (b_almost_empty),
        .count        (b_count),
        .overflow     (b_overflow),
        .underflow    (b_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int cnt, input bit e, input bit ae,
                             input bit af, input bit f);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".full"}, 32'(full), 32'(f));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b0; clr_err = 1'b0;
        b_wr_en = 1'b0; b_wr_data = '0; b_rd_en = 1'b0; b_clr_err = 1'b0;

        // Reset held two cycles with wr_en high
        tick(); tick();
        chk_flags("reset", 0, 1, 1, 0, 0);
        chk("reset.rd_valid", 32'(rd_valid), 0);
        chk("reset.rd_data", 32'(rd_data), 0);
        chk("reset.overflow", 32'(overflow), 0);
        chk("reset.underflow", 32'(underflow), 0);
        chk("reset.fwft_rd_valid", 32'(b_rd_valid), 0);
        chk("reset.fwft_rd_data", 32'(b_rd_data), 0);
        rst = 1'b0; wr_en = 1'b0;
        tick();
        chk("reset.no_write", 32'(count), 0);

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            chk_flags($sformatf("fill%0d", i), i, 0, (i <= 2), (i >= 6), (i == 8));
        end
        wr_data = 8'h09;
        tick();
        wr_en = 1'b0;
        chk("fill9.count", 32'(count), 8);
        chk("fill9.full", 32'(full), 1);
        chk("fill9.overflow", 32'(overflow), 1);

        // Drain in standard mode
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("drain%0d.rd_valid", i), 32'(rd_valid), 1);
            chk($sformatf("drain%0d.rd_data", i), 32'(rd_data), 32'(i));
            chk_flags($sformatf("drain%0d", i), 8 - i, (i == 8), (8 - i <= 2), (8 - i >= 6), 0);
        end
        tick();
        rd_en = 1'b0;
        chk("drain9.rd_valid", 32'(rd_valid), 0);
        chk("drain9.rd_data_hold", 32'(rd_data), 8);
        chk("drain9.underflow", 32'(underflow), 1);
        chk("drain9.overflow_sticky", 32'(overflow), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr.overflow", 32'(overflow), 0);
        chk("clr.underflow", 32'(underflow), 0);

        // Streaming from count 3 across the pointer wrap
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        chk_flags("prestream", 3, 0, 0, 0, 0);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data = 8'(8'h13 + k);
            tick();
            chk($sformatf("stream%0d.rd_data", k), 32'(rd_data), 32'(8'h10 + k));
            chk($sformatf("stream%0d.rd_valid", k), 32'(rd_valid), 1);
            chk_flags($sformatf("stream%0d", k), 3, 0, 0, 0, 0);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("tail%0d.rd_data", k), 32'(rd_data), 32'(8'h24 + k));
        end
        rd_en = 1'b0;
        chk("stream.overflow", 32'(overflow), 0);
        chk("stream.underflow", 32'(underflow), 0);
        chk("stream.empty", 32'(empty), 1);

        // Reset in mid-operation
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            tick();
        end
        chk("premid.count", 32'(count), 5);
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk_flags("midrst", 0, 1, 1, 0, 0);
        chk("midrst.rd_valid", 32'(rd_valid), 0);
        chk("midrst.rd_data", 32'(rd_data), 0);
        chk("midrst.overflow", 32'(overflow), 0);
        chk("midrst.underflow", 32'(underflow), 0);
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        chk("post.count", 32'(count), 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post.rd_data", 32'(rd_data), 8'h5A);
        chk("post.rd_valid", 32'(rd_valid), 1);

        // Simultaneous read+write while empty: write wins, underflow sets
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h66;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("emptyrw.count", 32'(count), 1);
        chk("emptyrw.underflow", 32'(underflow), 1);
        chk("emptyrw.rd_valid", 32'(rd_valid), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("emptyrw.rd_data", 32'(rd_data), 8'h66);

        // FWFT: word visible the cycle after its write, without rd_en
        chk("fwft.idle_valid", 32'(b_rd_valid), 0);
        b_wr_en = 1'b1; b_wr_data = 8'hA5;
        tick();
        b_wr_en = 1'b0;
        chk("fwft.rd_valid", 32'(b_rd_valid), 1);
        chk("fwft.rd_data", 32'(b_rd_data), 8'hA5);
        chk("fwft.count", 32'(b_count), 1);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        chk("fwft.pop_empty", 32'(b_empty), 1);
        chk("fwft.pop_valid", 32'(b_rd_valid), 0);
        chk("fwft.underflow", 32'(b_underflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO. Generalises the team's 4-bit x 8 synchronous FIFO to any width and any power-of-two depth. Adds registered fill count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain, as the standard buffering primitive for the next designs.

## Interface
- `DATA_WIDTH`, default 8: word width in bits, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥4.
- `ADDR_WIDTH`, default log2(DEPTH): derived localparam, not overridden.
- `FWFT`, default 0: 0 = standard registered read; 1 = first-word-fall-through.
- `AF_LEVEL`, default DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, default 2: `almost_empty` asserts when count ≤ AE_LEVEL.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: write request.
- `wr_data` in DATA_WIDTH: write word.
- `rd_en` in 1: read request (FWFT: acknowledge of the head word).
- `clr_err` in 1: clears the sticky error flags.
- `rd_data` out DATA_WIDTH: read word.
- `rd_valid` out 1: `rd_data` is valid.
- `full`, `empty` out 1: registered occupancy flags.
- `almost_full`, `almost_empty` out 1: registered threshold flags.
- `count` out ADDR_WIDTH+1: entries held, 0..DEPTH.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- **Pointers:** `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits. The low bits address the storage; the MSB is the wrap bit. Both wrap modulo 2·DEPTH naturally.
- **Accept rules:**
  - Write accepted iff `wr_en` && !`full`. An accepted write stores the word at `wr_ptr` and increments `wr_ptr`.
  - Read accepted iff `rd_en` && !`empty`. An accepted read increments `rd_ptr`.
- **Simultaneous read and write:**
  - When neither flag blocks, both are accepted and `count` is unchanged.
  - When `full`: the read is accepted, the write is rejected, and `overflow` sets.
  - When `empty`: the write is accepted, the read is rejected, and `underflow` sets.
- **Count:** next count = count + wr_acc − rd_acc.
- **Flags:** all flags are registered from next count, on the same edge as the pointers.
  - `full` = (count == DEPTH).
  - `empty` = (count == 0).
  - `almost_full` = (count ≥ AF_LEVEL).
  - `almost_empty` = (count ≤ AE_LEVEL).
- **Standard mode (FWFT=0):** on an accepted read, `rd_data` registers mem[rd_ptr] and `rd_valid` pulses high for one cycle. Otherwise `rd_data` holds its value and `rd_valid` is 0.
- **FWFT mode:**
  - `rd_data` = mem[rd_ptr low bits], read combinationally from the flop array.
  - `rd_valid` = !`empty`.
  - `rd_en` pops the head word; the next word appears in the following cycle.
- **Errors:**
  - `overflow` sets on `wr_en` && `full`; `underflow` sets on `rd_en` && `empty`.
  - Both hold until `clr_err`.
  - If `clr_err` and a new error occur in the same cycle, the set wins.
- **Reset:**
  - Values after reset: pointers 0, `count` 0, `empty` 1, `almost_empty` 1, `full` 0, `almost_full` 0, `rd_valid` 0, `rd_data` 0, `overflow` 0, `underflow` 0.
  - Storage contents are not reset.
  - Reset in mid-operation discards all contents. It dominates every other input in that cycle.

## Timing
- Write at edge N:
  - `count`, `empty`, `full` and the almost flags reflect it after edge N.
  - In FWFT mode, the word is on `rd_data` with `rd_valid`=1 in the cycle after edge N.
- Standard read accepted at edge N: `rd_data` and `rd_valid` are valid in the cycle after edge N (read latency 1).
- Maximum throughput is one write and one read per cycle, sustained, with no bubbles at the wrap-around.
- `full` drops one cycle after the first read from a full FIFO; write again only once `full` is low.

## Structure
- Shared package `fifo_pkg`:
  - `clog2` function.
  - Default `DATA_WIDTH` and `DEPTH` constants.
  - Compile-time checks: DEPTH is a power of two; AE_LEVEL < AF_LEVEL ≤ DEPTH.
- One sub-module, `sfifo_ram`: a DEPTH×DATA_WIDTH flop array with a synchronous write port and an asynchronous read port.
- The top level holds the pointers, count, flags, errors and the FWFT/standard output stage.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 unless noted.
- **Reset:** hold `rst` 2 cycles with `wr_en`=1 → `empty`=1, `almost_empty`=1, `count`=0, `rd_valid`=0, no write accepted.
- **Fill:** write 0x01..0x08 on consecutive cycles →
  - `almost_empty` falls after the 3rd write.
  - `almost_full` rises after the 6th write.
  - `full`=1 and `count`=8 after the 8th write.
  - A 9th write (0x09) is rejected and sets `overflow`; `count` stays 8.
- **Drain, standard mode:** read 9 times → `rd_data` = 0x01..0x08, each one cycle after its `rd_en`. `empty` after the 8th read. The 9th read sets `underflow`. `clr_err` clears both error flags.
- **Streaming:** from `count`=3, assert `wr_en` and `rd_en` together for 20 cycles with an incrementing pattern →
  - `count` stays 3, and no flag changes.
  - Data comes out in order across the pointer wrap-around.
- **FWFT=1:** write 0xA5 to an empty FIFO → `rd_valid`=1 and `rd_data`=0xA5 the next cycle without `rd_en`. Then `rd_en` → `empty` and `rd_valid`=0 the following cycle.
- **Reset mid-operation:** assert `rst` at `count`=5 with both enables high → all outputs return to reset values the next cycle. A subsequent write and read returns the new word, not stale data.
